// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode encodings, FSM state encoding and a small opcode
// classification helper shared by alu_mc and alu_mc_muldiv.
package alu_mc_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_INA   = 5'd11;
  localparam logic [4:0] OP_LUI   = 5'd12;
  localparam logic [4:0] OP_MUL   = 5'd13;
  localparam logic [4:0] OP_MULHU = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_REMU  = 5'd16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv: iterative unsigned multiply (shift-add) and restoring
// divide, one bit per clock, exactly WIDTH iterations per operation.
//
// Ports:
//   clk     - clock
//   rst_n   - synchronous active-low reset, aborts any operation in flight
//   start   - load operands and begin an operation (one-cycle pulse)
//   op      - OP_MUL / OP_MULHU / OP_DIVU / OP_REMU, captured with start
//   a, b    - operands, captured with start
//   done    - high during the cycle in which the last iteration is applied
//   result  - final value, valid only while done is high
//
// hi/lo hold {product high, product low} for multiply and
// {remainder, quotient} for divide. A zero divisor needs no special case:
// every trial subtract succeeds (quotient all ones) and the remainder ends
// up as the dividend shifted fully through.
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    count;
  logic             is_div;
  logic             want_hi;
  logic [WIDTH-1:0] hi, lo, opd;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   sum, r_sh, diff;
  logic             ge;

  always_comb begin
    sum    = '0;
    r_sh   = '0;
    diff   = '0;
    ge     = 1'b0;
    hi_nxt = hi;
    lo_nxt = lo;
    if (is_div) begin
      r_sh = {hi, lo[WIDTH-1]};
      ge   = (r_sh >= {1'b0, opd});
      diff = r_sh - {1'b0, opd};
      if (ge) begin
        hi_nxt = diff[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = r_sh[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum = lo[0] ? ({1'b0, hi} + {1'b0, opd}) : {1'b0, hi};
      {hi_nxt, lo_nxt} = {sum, lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      is_div  <= 1'b0;
      want_hi <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      opd     <= '0;
    end else if (start) begin
      count   <= CW'(WIDTH);
      is_div  <= (op == OP_DIVU) || (op == OP_REMU);
      want_hi <= (op == OP_MULHU) || (op == OP_REMU);
      hi      <= '0;
      lo      <= ((op == OP_DIVU) || (op == OP_REMU)) ? a : b;
      opd     <= ((op == OP_DIVU) || (op == OP_REMU)) ? b : a;
    end else if (count != '0) begin
      count <= count - 1'b1;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  // The final iteration is taken straight from the next-state logic so the
  // parent can register it on the same edge that ends the count.
  assign done   = (count == CW'(1));
  assign result = want_hi ? hi_nxt : lo_nxt;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes. Single-cycle ops
// complete one cycle after acceptance; MUL/MULHU/DIVU/REMU run through the
// iterative engine for WIDTH extra cycles.
//
// Build option: define ALU_MC_MULDIV_EN to include the iterative engine.
// Without it, MUL/MULHU/DIVU/REMU finish in one cycle with result 0.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid, in_ready   - request handshake; in_ready high only in IDLE
//   inA, inB, operation  - operands and opcode, captured on acceptance
//   out_valid, out_ready - result handshake; held in DONE until out_ready
//   result, zero         - registered result and (result == 0) flag
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for a request, in_ready = 1
// CALC    | iterative multiply/divide running
// DONE    | result presented, out_valid = 1, waiting out_ready
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [4:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic             load;
  logic [WIDTH-1:0] alu, res_in;
  logic [SHW-1:0]   shamt;

`ifdef ALU_MC_MULDIV_EN
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op     (operation),
    .a      (inA),
    .b      (inB),
    .done   (md_done),
    .result (md_result)
  );
`endif

  assign shamt = inA[SHW-1:0];

  always_comb begin
    alu = inA;
    case (operation)
      OP_ADD:  alu = inA + inB;
      OP_SUB:  alu = inA - inB;
      OP_AND:  alu = inA & inB;
      OP_OR:   alu = inA | inB;
      OP_XOR:  alu = inA ^ inB;
      OP_NOR:  alu = ~(inA | inB);
      OP_SLT:  alu = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
      OP_SLTU: alu = {{(WIDTH-1){1'b0}}, (inA < inB)};
      OP_SLL:  alu = inB << shamt;
      OP_SRL:  alu = inB >> shamt;
      OP_SRA:  alu = $signed(inB) >>> shamt;
      OP_INA:  alu = inA;
      OP_LUI:  alu = {inB[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      // Mul/div opcodes only land here when the engine is left out.
      default: alu = is_muldiv(operation) ? '0 : inA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
`ifdef ALU_MC_MULDIV_EN
    md_start  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef ALU_MC_MULDIV_EN
          if (is_muldiv(operation)) begin
            md_start  = 1'b1;
            state_nxt = ST_CALC;
          end else begin
            load      = 1'b1;
            state_nxt = ST_DONE;
          end
`else
          load      = 1'b1;
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_CALC: begin
`ifdef ALU_MC_MULDIV_EN
        if (md_done) begin
          load      = 1'b1;
          state_nxt = ST_DONE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    res_in = alu;
`ifdef ALU_MC_MULDIV_EN
    if (state == ST_CALC) res_in = md_result;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (load) begin
      result <= res_in;
      zero   <= (res_in == '0);
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have in_valid  input  1  operation request.
REQ-005 SHALL have in_ready  output  1  block can accept a request.
REQ-006 SHALL have inA  input  WIDTH  first operand.
REQ-007 SHALL have inB  input  WIDTH  second operand.
REQ-008 SHALL have operation  input  5  opcode, encodings from alu_mc_pkg.
REQ-009 SHALL have out_valid  output  1  result/zero valid.
REQ-010 SHALL have out_ready  input  1  consumer accepts result.
REQ-011 SHALL have result  output  WIDTH  registered result.
REQ-012 SHALL have zero  output  1  registered; 1 iff result == 0.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request when in_valid & in_ready; inA, inB, operation captured that edge.
REQ-015 SHALL move single-cycle ops IDLE->DONE: out_valid asserted the cycle after acceptance (latency 1).
REQ-016 SHALL move MUL, MULHU, DIVU, REMU IDLE->CALC, iterate exactly WIDTH cycles, then ->DONE (out_valid at acceptance+WIDTH+1).
REQ-017 SHALL hold result, zero, out_valid stable in DONE until out_ready = 1; then -> IDLE the next cycle (no back-to-back accept in the same cycle as output handshake).
REQ-018 SHALL ignore in_valid while not in IDLE; operand/opcode changes then have no effect.
REQ-019 SHALL compute single-cycle ops: ADD, SUB (mod 2^WIDTH, carries dropped); AND; OR; XOR; NOR = ~(A|B); SLT signed compare; SLTU unsigned compare (result 1 or 0, zero-extended).
REQ-020 SHALL compute shifts with amount inA[log2(WIDTH)-1:0]: SLL = inB <<; SRL logical; SRA arithmetic (sign bit replicated).
REQ-021 SHALL compute INA = inA; LUI = {inB[WIDTH/2-1:0], WIDTH/2 zeros}; undefined opcodes return inA.
REQ-022 SHALL compute MUL = low WIDTH bits of unsigned product; MULHU = high WIDTH bits (shift-add).
REQ-023 SHALL compute DIVU/REMU by restoring division; divisor 0 -> DIVU all ones, REMU = inA.

Reset
REQ-024 SHALL, when rst_n = 0 at a clock edge, force IDLE, result = 0, zero = 1, out_valid = 0, in_ready = 1 next cycle.
REQ-025 SHALL abort any CALC in progress on reset; no partial result ever presented.

Configuration
REQ-026 SHALL gate the iterative engine with macro ALU_MC_MULDIV_EN.
REQ-027 SHALL, with ALU_MC_MULDIV_EN defined, behave per REQ-016/022/023.
REQ-028 SHALL, without it, treat MUL/MULHU/DIVU/REMU as single-cycle ops returning 0 (zero = 1); CALC state unreachable; no muldiv instance.

Structure
REQ-029 SHALL place opcode localparams (5-bit) and FSM state encodings in shared package alu_mc_pkg.
REQ-030 SHALL put iterative multiply/divide in sub-module alu_mc_muldiv (start, done, WIDTH parameter); FSM and single-cycle datapath in alu_mc.

Verification
REQ-031 SHALL cover: WIDTH=32, ADD 0xFFFFFFFF+1 -> result 0, zero 1, out_valid 1 cycle after accept.
REQ-032 SHALL cover: SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; SRA inA=4, inB=0x80000000 -> 0xF8000000.
REQ-033 SHALL cover: MUL 0x10000 x 0x10000 -> 0; MULHU same -> 1; out_valid exactly 33 cycles after accept.
REQ-034 SHALL cover: DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0, new in_valid ignored.
REQ-036 SHALL cover: rst_n low at cycle 10 of a DIVU -> out_valid 0, in_ready 1 next cycle, result 0; then ADD 2+3 -> 5.
